// File: rtl/pkt_h.sv
// Header record shared by the header-info extraction path and the serializer.
package pkt_h;

  typedef struct packed {
    logic        valid;
    logic [47:0] sMAC;
    logic [47:0] dMAC;
    logic [31:0] sIP;
    logic [31:0] dIP;
    logic [15:0] sPort;
    logic [15:0] dPort;
    logic [31:0] seqNum;
    logic [31:0] size;
  } pkHeadInfo;

endpackage

// File: rtl/pkt_hdr_serializer.sv
// Serializes one pkHeadInfo record into a fixed-length valid/ready/last beat stream.
// Optional trailing XOR checksum beat when PKT_HDR_SER_CKSUM_EN is defined.
module pkt_hdr_serializer
  import pkt_h::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  pkHeadInfo         in_hdr,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic [CNT_W-1:0]  sent_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int NUM_BEATS = 256 / DATA_W;
  localparam int BI_W      = $clog2(NUM_BEATS);
`ifdef PKT_HDR_SER_CKSUM_EN
  localparam int LAST_IDX  = NUM_BEATS;
`else
  localparam int LAST_IDX  = NUM_BEATS - 1;
`endif
  localparam int IDX_W     = $clog2(LAST_IDX + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LAST_IDX);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [255:0]       payload_q, payload_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   sent_cnt_q, sent_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic [255:0]       hdr_payload;
  logic [DATA_W-1:0]  beat_arr [NUM_BEATS];
  logic [DATA_W-1:0]  data_beat;
  logic [DATA_W-1:0]  cur_beat;
  logic               is_last;
  logic               accept;
  logic               latch_new;

  // The valid bit is a control flag, not part of the transmitted payload.
  assign hdr_payload = {in_hdr.sMAC, in_hdr.dMAC, in_hdr.sIP, in_hdr.dIP,
                        in_hdr.sPort, in_hdr.dPort, in_hdr.seqNum, in_hdr.size};

  for (genvar gi = 0; gi < NUM_BEATS; gi++) begin : g_beat
    assign beat_arr[gi] = payload_q[255 - gi*DATA_W -: DATA_W];
  end

  assign data_beat = beat_arr[idx_q[BI_W-1:0]];

`ifdef PKT_HDR_SER_CKSUM_EN
  logic [DATA_W-1:0] acc_q, acc_d;
  assign cur_beat = (idx_q == IDX_LAST) ? acc_q : data_beat;
`else
  assign cur_beat = data_beat;
`endif

  assign is_last   = (state_q == SEND) && (idx_q == IDX_LAST);
  assign in_ready  = (state_q == IDLE) || (is_last && out_ready);
  assign accept    = in_valid && in_ready;
  assign latch_new = accept && in_hdr.valid;

  assign out_valid = (state_q == SEND);
  assign out_last  = is_last;
  assign busy      = (state_q == SEND);
  assign out_data  = (state_q == SEND) ? cur_beat : '0;
  assign sent_cnt  = sent_cnt_q;
  assign drop_cnt  = drop_cnt_q;

  always_comb begin
    state_d    = state_q;
    payload_d  = payload_q;
    idx_d      = idx_q;
    sent_cnt_d = sent_cnt_q;
    drop_cnt_d = drop_cnt_q;
`ifdef PKT_HDR_SER_CKSUM_EN
    acc_d      = acc_q;
`endif

    if (accept && !in_hdr.valid) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (latch_new) begin
          state_d   = SEND;
          payload_d = hdr_payload;
          idx_d     = '0;
`ifdef PKT_HDR_SER_CKSUM_EN
          acc_d     = '0;
`endif
        end
      end
      SEND: begin
        if (out_ready) begin
          if (!is_last) begin
            idx_d = idx_q + IDX_W'(1);
`ifdef PKT_HDR_SER_CKSUM_EN
            // Only data beats reach here, so the checksum is complete by the last beat.
            acc_d = acc_q ^ data_beat;
`endif
          end else begin
            sent_cnt_d = sent_cnt_q + CNT_W'(1);
            if (latch_new) begin
              payload_d = hdr_payload;
              idx_d     = '0;
`ifdef PKT_HDR_SER_CKSUM_EN
              acc_d     = '0;
`endif
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      payload_q  <= '0;
      idx_q      <= '0;
      sent_cnt_q <= '0;
      drop_cnt_q <= '0;
`ifdef PKT_HDR_SER_CKSUM_EN
      acc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      payload_q  <= payload_d;
      idx_q      <= idx_d;
      sent_cnt_q <= sent_cnt_d;
      drop_cnt_q <= drop_cnt_d;
`ifdef PKT_HDR_SER_CKSUM_EN
      acc_q      <= acc_d;
`endif
    end
  end

endmodule

// File: tb/tb_pkt_hdr_serializer.sv
// Self-checking bench for pkt_hdr_serializer: directed scenarios plus a randomized
// run against a queue-based beat model.
module tb_pkt_hdr_serializer;
  import pkt_h::*;

`ifdef PKT_HDR_SER_CKSUM_EN
  localparam int DW  = 64;
  localparam int TOT = 256 / DW + 1;
`else
  localparam int DW  = 32;
  localparam int TOT = 256 / DW;
`endif
  localparam int NB = 256 / DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  pkHeadInfo     in_hdr = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          busy;
  logic [15:0]   sent_cnt;
  logic [15:0]   drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_sent = 0;
  int exp_drop = 0;

  pkt_hdr_serializer #(.DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_hdr(in_hdr), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .sent_cnt(sent_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Payload assembled field by field with shifts, MSB first.
  function automatic logic [255:0] model_payload(input pkHeadInfo h);
    logic [255:0] p;
    p = 256'(h.sMAC);
    p = (p << 48) | 256'(h.dMAC);
    p = (p << 32) | 256'(h.sIP);
    p = (p << 32) | 256'(h.dIP);
    p = (p << 16) | 256'(h.sPort);
    p = (p << 16) | 256'(h.dPort);
    p = (p << 32) | 256'(h.seqNum);
    p = (p << 32) | 256'(h.size);
    return p;
  endfunction

  function automatic logic [DW-1:0] model_beat(input logic [255:0] p, input int k);
    logic [DW-1:0] x;
    if (k < NB) return DW'(p >> (256 - (k + 1) * DW));
    x = '0;
    for (int j = 0; j < NB; j++) x = x ^ DW'(p >> (256 - (j + 1) * DW));
    return x;
  endfunction

  function automatic pkHeadInfo known_hdr();
    pkHeadInfo h;
    h.valid  = 1'b1;
    h.sMAC   = 48'h001122334455;
    h.dMAC   = 48'h66778899AABB;
    h.sIP    = 32'h0A000001;
    h.dIP    = 32'h0A000002;
    h.sPort  = 16'h1234;
    h.dPort  = 16'h0050;
    h.seqNum = 32'd1;
    h.size   = 32'd64;
    return h;
  endfunction

  function automatic pkHeadInfo rand_hdr(input bit v);
    pkHeadInfo h;
    h.valid  = v;
    h.sMAC   = 48'({$urandom(), $urandom()});
    h.dMAC   = 48'({$urandom(), $urandom()});
    h.sIP    = $urandom();
    h.dIP    = $urandom();
    h.sPort  = 16'($urandom());
    h.dPort  = 16'($urandom());
    h.seqNum = $urandom();
    h.size   = $urandom();
    return h;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last: got %b want 0", out_last); else n_pass++;
    n_checks++; if (out_data !== '0) $display("FAIL reset_out_data: got %h want 0", out_data); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (sent_cnt !== 16'd0) $display("FAIL reset_sent_cnt: got %0d want 0", sent_cnt); else n_pass++;
    n_checks++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    pkHeadInfo     h;
    logic [255:0]  p;
    logic [DW-1:0] exp_beats [TOT];
    logic [DW-1:0] obs [TOT];
    h = known_hdr();
    p = model_payload(h);
    for (int k = 0; k < TOT; k++) exp_beats[k] = model_beat(p, k);
    in_hdr = h; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL single_in_ready_idle: got %b want 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL single_pre_valid: got %b want 0", out_valid); else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_hdr = rand_hdr(1'b1);
    for (int k = 0; k < TOT; k++) begin
      @(negedge clk);
      obs[k] = out_data;
      n_checks++; if (out_valid !== 1'b1) $display("FAIL single_valid beat %0d: got %b want 1", k, out_valid); else n_pass++;
      n_checks++; if (out_data !== exp_beats[k]) $display("FAIL single_data beat %0d: got %h want %h", k, out_data, exp_beats[k]); else n_pass++;
      n_checks++; if (out_last !== (k == TOT - 1)) $display("FAIL single_last beat %0d: got %b want %b", k, out_last, (k == TOT - 1)); else n_pass++;
      @(posedge clk); #1;
    end
    exp_sent++;
`ifdef PKT_HDR_SER_CKSUM_EN
    n_checks++; if (obs[0] !== 64'h0011223344556677) $display("FAIL single_const_b0: got %h want 0011223344556677", obs[0]); else n_pass++;
    n_checks++; if (obs[4] !== 64'h8288888B5C616666) $display("FAIL single_const_cksum: got %h want 8288888b5c616666", obs[4]); else n_pass++;
`else
    n_checks++; if (obs[0] !== 32'h00112233) $display("FAIL single_const_b0: got %h want 00112233", obs[0]); else n_pass++;
    n_checks++; if (obs[1] !== 32'h44556677) $display("FAIL single_const_b1: got %h want 44556677", obs[1]); else n_pass++;
    n_checks++; if (obs[7] !== 32'h00000040) $display("FAIL single_const_b7: got %h want 00000040", obs[7]); else n_pass++;
`endif
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL single_post_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL single_post_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (sent_cnt !== 16'(exp_sent)) $display("FAIL single_sent_cnt: got %0d want %0d", sent_cnt, exp_sent); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    pkHeadInfo     h;
    logic [255:0]  p;
    logic [DW-1:0] exp_beats [TOT];
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic          prev_stall;
    int            hs;
    int            cyc;
    h = known_hdr();
    p = model_payload(h);
    for (int k = 0; k < TOT; k++) exp_beats[k] = model_beat(p, k);
    in_hdr = h; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    hs = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    while (hs < TOT && cyc < 200) begin
      out_ready = (cyc % 3 == 0);
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid cycle %0d: got %b want 1", cyc, out_valid); else n_pass++;
      if (prev_stall) begin
        n_checks++; if (out_data !== prev_data) $display("FAIL bp_hold_data cycle %0d: got %h want %h", cyc, out_data, prev_data); else n_pass++;
        n_checks++; if (out_last !== prev_last) $display("FAIL bp_hold_last cycle %0d: got %b want %b", cyc, out_last, prev_last); else n_pass++;
      end
      if (out_valid && out_ready) begin
        n_checks++; if (out_data !== exp_beats[hs]) $display("FAIL bp_data beat %0d: got %h want %h", hs, out_data, exp_beats[hs]); else n_pass++;
        n_checks++; if (out_last !== (hs == TOT - 1)) $display("FAIL bp_last beat %0d: got %b want %b", hs, out_last, (hs == TOT - 1)); else n_pass++;
        hs++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++; if (hs != TOT) $display("FAIL bp_handshakes: got %0d want %0d", hs, TOT); else n_pass++;
    exp_sent++;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_post_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (sent_cnt !== 16'(exp_sent)) $display("FAIL bp_sent_cnt: got %0d want %0d", sent_cnt, exp_sent); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    pkHeadInfo     h1, h2;
    logic [255:0]  p;
    logic [DW-1:0] q [$];
    logic          exp_rdy;
    int            offered;
    int            seen;
    int            cyc;
    h1 = rand_hdr(1'b1);
    h2 = rand_hdr(1'b1);
    in_hdr = h1; in_valid = 1'b1; out_ready = 1'b1;
    offered = 0; seen = 0; cyc = 0;
    while ((offered < 2 || q.size() > 0) && cyc < 100) begin
      @(negedge clk);
      exp_rdy = (q.size() <= 1);
      n_checks++; if (in_ready !== exp_rdy) $display("FAIL b2b_in_ready cycle %0d: got %b want %b", cyc, in_ready, exp_rdy); else n_pass++;
      n_checks++; if (out_valid !== (q.size() > 0)) $display("FAIL b2b_valid cycle %0d: got %b want %b", cyc, out_valid, (q.size() > 0)); else n_pass++;
      if (q.size() > 0) begin
        n_checks++; if (out_data !== q[0]) $display("FAIL b2b_data cycle %0d: got %h want %h", cyc, out_data, q[0]); else n_pass++;
        void'(q.pop_front());
        seen++;
        if (q.size() == 0) exp_sent++;
      end
      if (in_valid && exp_rdy) begin
        p = model_payload(in_hdr);
        for (int k = 0; k < TOT; k++) q.push_back(model_beat(p, k));
        offered++;
      end
      @(posedge clk); #1;
      in_hdr   = (offered == 1) ? h2 : h1;
      in_valid = (offered < 2);
      cyc++;
    end
    n_checks++; if (seen != 2 * TOT) $display("FAIL b2b_beats: got %0d want %0d", seen, 2 * TOT); else n_pass++;
    @(negedge clk);
    n_checks++; if (sent_cnt !== 16'(exp_sent)) $display("FAIL b2b_sent_cnt: got %0d want %0d", sent_cnt, exp_sent); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_drop();
    in_hdr = rand_hdr(1'b0); in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL drop_in_ready: got %b want 1", in_ready); else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_drop++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) $display("FAIL drop_out_valid cycle %0d: got %b want 0", c, out_valid); else n_pass++;
      n_checks++; if (drop_cnt !== 16'(exp_drop)) $display("FAIL drop_cnt cycle %0d: got %0d want %0d", c, drop_cnt, exp_drop); else n_pass++;
      n_checks++; if (sent_cnt !== 16'(exp_sent)) $display("FAIL drop_sent_cnt cycle %0d: got %0d want %0d", c, sent_cnt, exp_sent); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    pkHeadInfo     h;
    logic [255:0]  p;
    h = rand_hdr(1'b1);
    p = model_payload(h);
    in_hdr = h; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++; if (out_data !== model_beat(p, k)) $display("FAIL rmid_pre_data beat %0d: got %h want %h", k, out_data, model_beat(p, k)); else n_pass++;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_sent = 0; exp_drop = 0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rmid_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (sent_cnt !== 16'd0) $display("FAIL rmid_sent_cnt: got %0d want 0", sent_cnt); else n_pass++;
    n_checks++; if (drop_cnt !== 16'd0) $display("FAIL rmid_drop_cnt: got %0d want 0", drop_cnt); else n_pass++;
    h = rand_hdr(1'b1);
    p = model_payload(h);
    in_hdr = h; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < TOT; k++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1) $display("FAIL rmid_post_valid beat %0d: got %b want 1", k, out_valid); else n_pass++;
      n_checks++; if (out_data !== model_beat(p, k)) $display("FAIL rmid_post_data beat %0d: got %h want %h", k, out_data, model_beat(p, k)); else n_pass++;
      @(posedge clk); #1;
    end
    exp_sent++;
    @(negedge clk);
    n_checks++; if (sent_cnt !== 16'(exp_sent)) $display("FAIL rmid_sent_cnt_after: got %0d want %0d", sent_cnt, exp_sent); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [255:0]  p;
    logic [DW-1:0] q [$];
    logic          exp_rdy;
    for (int cyc = 0; cyc < 700; cyc++) begin
      in_hdr    = rand_hdr($urandom_range(0, 3) != 0);
      in_valid  = (cyc < 600) ? ($urandom_range(0, 1) == 1) : 1'b0;
      out_ready = (cyc < 600) ? ($urandom_range(0, 9) < 6) : 1'b1;
      @(negedge clk);
      exp_rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
      n_checks++; if (in_ready !== exp_rdy) $display("FAIL rnd_in_ready cycle %0d: got %b want %b", cyc, in_ready, exp_rdy); else n_pass++;
      n_checks++; if (out_valid !== (q.size() > 0)) $display("FAIL rnd_valid cycle %0d: got %b want %b", cyc, out_valid, (q.size() > 0)); else n_pass++;
      n_checks++; if (sent_cnt !== 16'(exp_sent)) $display("FAIL rnd_sent_cnt cycle %0d: got %0d want %0d", cyc, sent_cnt, exp_sent); else n_pass++;
      n_checks++; if (drop_cnt !== 16'(exp_drop)) $display("FAIL rnd_drop_cnt cycle %0d: got %0d want %0d", cyc, drop_cnt, exp_drop); else n_pass++;
      if (q.size() > 0) begin
        n_checks++; if (out_data !== q[0]) $display("FAIL rnd_data cycle %0d: got %h want %h", cyc, out_data, q[0]); else n_pass++;
        n_checks++; if (out_last !== (q.size() == 1)) $display("FAIL rnd_last cycle %0d: got %b want %b", cyc, out_last, (q.size() == 1)); else n_pass++;
        if (out_ready) begin
          void'(q.pop_front());
          if (q.size() == 0) exp_sent++;
        end
      end
      if (in_valid && exp_rdy) begin
        if (in_hdr.valid) begin
          p = model_payload(in_hdr);
          for (int k = 0; k < TOT; k++) q.push_back(model_beat(p, k));
        end else begin
          exp_drop++;
        end
      end
      @(posedge clk); #1;
    end
    n_checks++; if (q.size() != 0) $display("FAIL rnd_drain: got %0d beats pending want 0", q.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_drop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
